// File: rtl/alu_seq.sv
// alu_seq: multi-precision issue sequencer for an external 8-bit combinational ALU.
//
// Takes an NBYTES-wide request (valid/ready). It walks the operands one byte at
// a time, LSB first. A carry or borrow out of byte i-1 is folded into byte i by
// an extra ALU pass (FIX) that adds or subtracts 1. The full-width result and
// the zero/carry/overflow flags are returned over a valid/ready response port.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op                     00 ADD, 01 SUB, 10 AND, 11 OR
//   req_a, req_b               operands, 8*NBYTES bits
//   rsp_valid/rsp_ready        response handshake
//   rsp_result                 full-width result
//   rsp_zero/carry/overflow    result flags (carry is the borrow for SUB)
//   alu_a, alu_b, alu_op       byte operands and operation driven to the ALU
//   alu_result/carry/zero      ALU byte result and flags
//
// Optional feature macro ALU_SEQ_STATS_EN adds these outputs:
//   sticky_ovf   goes to 1 when a response with overflow is handed off; only reset clears it
//   op_count     16-bit count of response handshakes, wraps around
module alu_seq #(
  parameter int unsigned NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_result,
  output logic                rsp_zero,
  output logic                rsp_carry,
  output logic                rsp_overflow,
`ifdef ALU_SEQ_STATS_EN
  output logic                sticky_ovf,
  output logic [15:0]         op_count,
`endif
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [1:0]          alu_op,
  input  logic [7:0]          alu_result,
  input  logic                alu_carry,
  input  logic                alu_zero
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {StIdle, StPass, StFix, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [1:0]        r_op;
  logic [W-1:0]      r_a, r_b, r_result;
  logic [IW-1:0]     r_idx;
  logic              r_cin, r_c1;
  logic [NBYTES-1:0] r_bz;
  logic              r_zero, r_carry, r_ovf;

  logic              w_arith, w_last, w_accept, w_handoff, w_advance, w_cout, w_ovf;
  logic [7:0]        w_a_byte, w_b_byte, w_res_byte;
  logic [NBYTES-1:0] w_bz;

  always_comb begin
    w_a_byte   = r_a[8*r_idx +: 8];
    w_b_byte   = r_b[8*r_idx +: 8];
    w_res_byte = r_result[8*r_idx +: 8];
    w_arith    = ~r_op[1];
    w_last     = (r_idx == IW'(NBYTES - 1));
    w_accept   = (r_state == StIdle) && req_valid;
    w_handoff  = (r_state == StDone) && rsp_ready;
    // A PASS with a pending carry-in must be followed by a FIX pass.
    w_advance  = ((r_state == StPass) && !(w_arith && r_cin)) || (r_state == StFix);
    // In FIX the byte carry is the carry of the PASS or the carry of the FIX.
    w_cout     = (r_state == StFix) ? (r_c1 | alu_carry) : (w_arith & alu_carry);
    w_bz         = r_bz;
    w_bz[r_idx]  = alu_zero;
    // The MSB of the result is the byte being written on the final edge.
    unique case (r_op)
      2'b00:   w_ovf = (~r_a[W-1] & ~r_b[W-1] &  alu_result[7]) |
                       ( r_a[W-1] &  r_b[W-1] & ~alu_result[7]);
      2'b01:   w_ovf = (~r_a[W-1] &  r_b[W-1] &  alu_result[7]) |
                       ( r_a[W-1] & ~r_b[W-1] & ~alu_result[7]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = 2'b00;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (w_accept) w_state_d = StPass;
      end
      StPass: begin
        alu_a  = w_a_byte;
        alu_b  = w_b_byte;
        alu_op = r_op;
        if (w_arith && r_cin) w_state_d = StFix;
        else if (w_last)      w_state_d = StDone;
      end
      StFix: begin
        alu_a     = w_res_byte;
        alu_b     = 8'h01;
        alu_op    = r_op;
        w_state_d = w_last ? StDone : StPass;
      end
      StDone: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_cin    <= 1'b0;
      r_c1     <= 1'b0;
      r_bz     <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op;
        r_a   <= req_a;
        r_b   <= req_b;
        r_idx <= '0;
        r_cin <= 1'b0;
      end
      if ((r_state == StPass) || (r_state == StFix)) begin
        r_result[8*r_idx +: 8] <= alu_result;
        r_bz                   <= w_bz;
      end
      if (r_state == StPass) r_c1 <= alu_carry;
      if (w_advance) begin
        r_cin <= w_cout;
        if (w_last) begin
          r_idx   <= '0;
          r_zero  <= &w_bz;
          r_carry <= w_cout;
          r_ovf   <= w_ovf;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

  assign rsp_result   = r_result;
  assign rsp_zero     = r_zero;
  assign rsp_carry    = r_carry;
  assign rsp_overflow = r_ovf;

`ifdef ALU_SEQ_STATS_EN
  logic        r_sticky_ovf;
  logic [15:0] r_op_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky_ovf <= 1'b0;
      r_op_count   <= 16'h0000;
    end else if (w_handoff) begin
      r_op_count <= r_op_count + 16'h0001;
      if (r_ovf) r_sticky_ovf <= 1'b1;
    end
  end

  assign sticky_ovf = r_sticky_ovf;
  assign op_count   = r_op_count;
`else
  logic w_unused;
  assign w_unused = w_handoff;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with NBYTES=2. A small
// behavioural 8-bit ALU answers the sequencer's byte passes.
module tb_alu_seq;

  localparam int unsigned NBYTES = 2;
  localparam int unsigned W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_carry, rsp_overflow;
  logic [7:0]   alu_a, alu_b, alu_result;
  logic [1:0]   alu_op;
  logic         alu_carry, alu_zero;
`ifdef ALU_SEQ_STATS_EN
  logic         sticky_ovf;
  logic [15:0]  op_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(NBYTES)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
`ifdef ALU_SEQ_STATS_EN
    .sticky_ovf   (sticky_ovf),
    .op_count     (op_count),
`endif
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero)
  );

  // Reference byte ALU; for SUB the carry output is the borrow.
  logic [8:0] w_alu_full;
  always_comb begin
    w_alu_full = 9'h000;
    case (alu_op)
      2'b00:   w_alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   w_alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   w_alu_full = {1'b0, alu_a & alu_b};
      default: w_alu_full = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_result = w_alu_full[7:0];
  assign alu_carry  = w_alu_full[8];
  assign alu_zero   = (w_alu_full[7:0] == 8'h00);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency from the accept edge, check the
  // response, and then hand the response off.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_z,
                        input logic exp_c, input logic exp_o, input int exp_lat);
    int lat;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, " latency"}, lat, exp_lat);
    check_val({tag, " result"}, {16'h0, rsp_result}, {16'h0, exp_r});
    check_val({tag, " zero"}, {31'h0, rsp_zero}, {31'h0, exp_z});
    check_val({tag, " carry"}, {31'h0, rsp_carry}, {31'h0, exp_c});
    check_val({tag, " ovf"}, {31'h0, rsp_overflow}, {31'h0, exp_o});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val({tag, " valid drop"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst req_ready", {31'h0, req_ready}, 32'h1);
    check_val("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_val("rst result", {16'h0, rsp_result}, 32'h0);
    check_val("rst flags", {29'h0, rsp_zero, rsp_carry, rsp_overflow}, 32'h0);
    check_val("rst alu", {14'h0, alu_a, alu_b, alu_op}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First op, stepped by hand to observe the individual ALU passes.
    req_op = 2'b00; req_a = 16'h00FF; req_b = 16'h0001; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("p0 alu", {14'h0, alu_a, alu_b, alu_op}, {14'h0, 8'hFF, 8'h01, 2'b00});
    check_val("p0 req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    check_val("p1 alu", {14'h0, alu_a, alu_b, alu_op}, {14'h0, 8'h00, 8'h00, 2'b00});
    @(posedge clk); #1;
    check_val("fix alu", {14'h0, alu_a, alu_b, alu_op}, {14'h0, 8'h00, 8'h01, 2'b00});
    @(posedge clk); #1;
    check_val("add1 valid", {31'h0, rsp_valid}, 32'h1);
    check_val("add1 result", {16'h0, rsp_result}, 32'h0100);
    check_val("add1 flags", {29'h0, rsp_zero, rsp_carry, rsp_overflow}, 32'h0);
    check_val("done alu", {14'h0, alu_a, alu_b, alu_op}, 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("add1 idle", {30'h0, req_ready, rsp_valid}, 32'h2);

    run_op("add_ffff", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 3);
    run_op("add_7fff", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 3);
    run_op("sub_0000", 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 3);
    run_op("sub_0100", 2'b01, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0, 3);
    run_op("and", 2'b10, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 2);
    run_op("add_nofix", 2'b00, 16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0, 1'b0, 2);
    run_op("sub_ovf", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 3);

    // Backpressure: hold the response while a new request is also presented.
    req_op = 2'b11; req_a = 16'h1234; req_b = 16'h00F0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = 2'b00; req_a = 16'hFFFF; req_b = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    check_val("bp valid", {31'h0, rsp_valid}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      check_val("bp hold", {13'h0, req_ready, rsp_valid, rsp_zero, rsp_result},
                {13'h0, 1'b0, 1'b1, 1'b0, 16'h12F4});
      check_val("bp flags", {30'h0, rsp_carry, rsp_overflow}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("bp release", {30'h0, req_ready, rsp_valid}, 32'h2);

    // Reset in the middle of a PASS discards the operation.
    req_op = 2'b00; req_a = 16'h00FF; req_b = 16'h0001; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("mrst ready/valid", {30'h0, req_ready, rsp_valid}, 32'h2);
    check_val("mrst result", {16'h0, rsp_result}, 32'h0);
    check_val("mrst flags", {29'h0, rsp_zero, rsp_carry, rsp_overflow}, 32'h0);
    check_val("mrst alu", {14'h0, alu_a, alu_b, alu_op}, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_val("mrst no rsp", {31'h0, rsp_valid}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
